// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared defaults for the enable-gated modulo counter family.
//   COUNTER_WIDTH_DEFAULT : default count register width
//   COUNTER_MAX_DEFAULT   : default terminal count (modulo = value + 1)
//   count_t               : count type at the default width
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 4;
  localparam int COUNTER_MAX_DEFAULT   = 9;

  typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/enable_pulse_counter.sv
// enable_pulse_counter
//   Modulo-(MAX_COUNT+1) event counter that advances only on enabled cycles
//   and emits a one-cycle strobe in the cycle after each wrap to zero.
//   Typical use is as a prescaler / tick generator.
//
// Ports
//   clk          : system clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   enable       : count enable
//   count_pulse  : registered strobe, high for the cycle following a wrap
//   count        : registered current count, 0..MAX_COUNT
module enable_pulse_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter int MAX_COUNT = COUNTER_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             count_pulse,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  // MAX_COUNT of 0 would make the strobe permanently high; anything above
  // the register range could never be reached.
  if (MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_params
    $error("enable_pulse_counter: MAX_COUNT=%0d illegal for WIDTH=%0d",
           MAX_COUNT, WIDTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      count_pulse <= 1'b0;
    end else if (enable) begin
      if (count == MAX_VAL) begin
        count       <= '0;
        count_pulse <= 1'b1;
      end else begin
        count       <= count + WIDTH'(1);
        count_pulse <= 1'b0;
      end
    end else begin
      count_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enable_pulse_counter.sv
// tb_enable_pulse_counter
//   Directed bench for enable_pulse_counter. Three instances share clock,
//   reset and enable: defaults (4/9), full 3-bit range (3/7) and the
//   shortest period (3/1). A tiny reference counter per instance supplies
//   the cycle-by-cycle expectations; key points are also checked against
//   hand-computed constants.
module tb_enable_pulse_counter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       pulse0, pulse1, pulse2;
  logic [3:0] count0;
  logic [2:0] count1, count2;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  int m0_cnt, m1_cnt, m2_cnt;
  int m0_p, m1_p, m2_p;

  int edge_idx;
  int pulse_total;
  int pulse_edges[$];

  enable_pulse_counter #(.WIDTH(4), .MAX_COUNT(9)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .count_pulse(pulse0), .count(count0));

  enable_pulse_counter #(.WIDTH(3), .MAX_COUNT(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .count_pulse(pulse1), .count(count1));

  enable_pulse_counter #(.WIDTH(3), .MAX_COUNT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .count_pulse(pulse2), .count(count2));

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rn, input logic en, input int maxc,
                            inout int cnt, inout int p);
    if (!rn) begin
      cnt = 0;
      p   = 0;
    end else if (en) begin
      p   = (cnt == maxc) ? 1 : 0;
      cnt = (cnt == maxc) ? 0 : cnt + 1;
    end else begin
      p = 0;
    end
  endtask

  // One clock edge with the given inputs, then check all instances.
  task automatic tick(input logic rn, input logic en, input string tag);
    rst_n  = rn;
    enable = en;
    @(posedge clk);
    #1;
    model_step(rn, en, 9, m0_cnt, m0_p);
    model_step(rn, en, 7, m1_cnt, m1_p);
    model_step(rn, en, 1, m2_cnt, m2_p);
    edge_idx++;
    if (pulse0 === 1'b1) begin
      pulse_total++;
      pulse_edges.push_back(edge_idx);
    end
    check({tag, ".cnt0"}, 32'(count0), 32'(m0_cnt));
    check({tag, ".pls0"}, 32'(pulse0), 32'(m0_p));
    check({tag, ".cnt1"}, 32'(count1), 32'(m1_cnt));
    check({tag, ".pls1"}, 32'(pulse1), 32'(m1_p));
    check({tag, ".cnt2"}, 32'(count2), 32'(m2_cnt));
    check({tag, ".pls2"}, 32'(pulse2), 32'(m2_p));
    check({tag, ".rng0"}, 32'(count0 <= 4'd9), 32'd1);
    check({tag, ".rng2"}, 32'(count2 <= 3'd1), 32'd1);
  endtask

  task automatic clear_window();
    edge_idx    = 0;
    pulse_total = 0;
    pulse_edges.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    m0_cnt = 0; m1_cnt = 0; m2_cnt = 0;
    m0_p = 0; m1_p = 0; m2_p = 0;
    clear_window();

    // reset, including with enable high
    tick(1'b0, 1'b0, "rst_init");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, "rst_en");
    check("rst.count0", 32'(count0), 32'd0);
    check("rst.pulse0", 32'(pulse0), 32'd0);

    // basic wrap: 15 enabled edges
    clear_window();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, "wrap");
    check("wrap.final_count", 32'(count0), 32'd5);
    check("wrap.pulse_total", 32'(pulse_total), 32'd1);
    check("wrap.pulse_edge", 32'(pulse_edges[0]), 32'd10);
    check("wrap.count1", 32'(count1), 32'd7);   // 15 mod 8
    check("wrap.count2", 32'(count2), 32'd1);   // 15 mod 2

    // enable gap
    tick(1'b0, 1'b0, "gap_rst");
    clear_window();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, "gap_run1");
    check("gap.count_before", 32'(count0), 32'd5);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, "gap_hold");
    check("gap.count_held", 32'(count0), 32'd5);
    check("gap.no_pulse", 32'(pulse_total), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, "gap_run2");
    check("gap.wrap_count", 32'(count0), 32'd0);
    check("gap.wrap_pulse", 32'(pulse0), 32'd1);
    check("gap.pulse_total", 32'(pulse_total), 32'd1);

    // enable dropped right after the wrap: pulse clears, count holds 0
    tick(1'b1, 1'b0, "drop_after_wrap");
    check("drop.pulse0", 32'(pulse0), 32'd0);
    check("drop.count0", 32'(count0), 32'd0);

    // back-to-back wraps over 30 enabled edges
    tick(1'b0, 1'b0, "b2b_rst");
    clear_window();
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, "b2b");
    check("b2b.pulse_total", 32'(pulse_total), 32'd3);
    if (pulse_edges.size() == 3) begin
      check("b2b.edge1", 32'(pulse_edges[0]), 32'd10);
      check("b2b.edge2", 32'(pulse_edges[1]), 32'd20);
      check("b2b.edge3", 32'(pulse_edges[2]), 32'd30);
    end

    // reset mid-count
    tick(1'b0, 1'b0, "mid_rst0");
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, "mid_run");
    check("mid.count7", 32'(count0), 32'd7);
    tick(1'b0, 1'b1, "mid_rst");
    check("mid.count_clr", 32'(count0), 32'd0);
    check("mid.pulse_clr", 32'(pulse0), 32'd0);
    clear_window();
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, "mid_after");
    check("mid.pulse_total", 32'(pulse_total), 32'd1);
    if (pulse_edges.size() > 0)
      check("mid.first_pulse", 32'(pulse_edges[0]), 32'd10);

    // reset arriving while a pulse is showing clears it
    tick(1'b0, 1'b0, "pend_rst0");
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, "pend_run");
    tick(1'b1, 1'b1, "pend_wrap");
    check("pend.pulse_set", 32'(pulse0), 32'd1);
    tick(1'b0, 1'b1, "pend_rst");
    check("pend.pulse_clr", 32'(pulse0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
